init_sequencer: RTL and testbench

- Power-on and on-demand initialisation controller for the branch-prediction and architectural state of the pipelined core: BTB, BHT, register file and data memory.
- Walks each target in a fixed order, one write per cycle, over a shared address/data bus with per-target write enables.
- Holds the core stalled while a walk is in progress.
- Also serves a lighter "predictor flush" request, which re-walks only BTB and BHT.

---
 rtl/init_seq_pkg.sv | 35 +++
 rtl/mem_init_rom.sv | 12 +
 rtl/init_sequencer.sv | 146 ++++++++++++++
 tb/tb_init_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/init_seq_pkg.sv
// Shared types, default sizes and the data-memory init image for the init sequencer.
// Pure declarations only; there is no logic, latency or flow control here.
package init_seq_pkg;

   typedef enum logic [2:0] {
      S_BTB  = 3'd0,
      S_BHT  = 3'd1,
      S_REG  = 3'd2,
      S_MEM  = 3'd3,
      S_IDLE = 3'd4
   } state_e;

   localparam int unsigned BTB_DEPTH_DEF = 256;
   localparam int unsigned BHT_DEPTH_DEF = 256;
   localparam int unsigned REG_DEPTH_DEF = 32;
   localparam int unsigned MEM_WORDS_DEF = 27;
   localparam int unsigned DATA_W_DEF    = 40;
   localparam logic [1:0]  BHT_INIT_DEF  = 2'b00;
   localparam int unsigned ROM_IDX_W     = 5;
   localparam int unsigned ROM_VAL_W     = 32;

   // Program image: a descending ramp 9..1, an ascending ramp 1..9, then zeros.
   function automatic logic [ROM_VAL_W-1:0] mem_init_value(input logic [ROM_IDX_W-1:0] idx);
      logic [ROM_VAL_W-1:0] v;
      if (idx <= 5'd8) begin
         v = ROM_VAL_W'(5'd9 - idx);
      end else if (idx <= 5'd17) begin
         v = ROM_VAL_W'(idx - 5'd8);
      end else begin
         v = '0;
      end
      return v;
   endfunction

endpackage

// File: rtl/mem_init_rom.sv
// Combinational data-memory init image, indexed by word number.
// Zero latency, no flow control; edit the image in the package function.
module mem_init_rom
   import init_seq_pkg::*;
(
   input  logic [ROM_IDX_W-1:0] idx_i,
   output logic [ROM_VAL_W-1:0] val_o
);

   assign val_o = mem_init_value(idx_i);

endmodule

// File: rtl/init_sequencer.sv
// Walks BTB, BHT, register file and data memory with one write per cycle, stalling the core.
// Outputs are registered; requests arriving while busy are dropped, never queued.
module init_sequencer
   import init_seq_pkg::*;
#(
   parameter int unsigned BTB_DEPTH = BTB_DEPTH_DEF,
   parameter int unsigned BHT_DEPTH = BHT_DEPTH_DEF,
   parameter int unsigned REG_DEPTH = REG_DEPTH_DEF,
   parameter int unsigned MEM_WORDS = MEM_WORDS_DEF,
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter logic [1:0]  BHT_INIT  = BHT_INIT_DEF
)(
   input  logic              clk,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              bp_flush_i,
   output logic              btb_we_o,
   output logic              bht_we_o,
   output logic              reg_we_o,
   output logic              mem_we_o,
   output logic [7:0]        init_addr_o,
   output logic [DATA_W-1:0] init_data_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam logic [7:0] BTB_LAST = 8'(BTB_DEPTH - 1);
   localparam logic [7:0] BHT_LAST = 8'(BHT_DEPTH - 1);
   localparam logic [7:0] REG_LAST = 8'(REG_DEPTH - 1);
   localparam logic [7:0] MEM_LAST = 8'(MEM_WORDS - 1);

   state_e              state_q;
   logic [7:0]          cnt_q;
   logic                flush_q;
   logic                btb_we_q;
   logic                bht_we_q;
   logic                reg_we_q;
   logic                mem_we_q;
   logic [7:0]          addr_q;
   logic [DATA_W-1:0]   data_q;
   logic                busy_q;
   logic                done_q;

   logic [DATA_W-1:0]    data_d;
   logic                 last_d;
   state_e               next_tgt_d;
   logic [ROM_VAL_W-1:0] rom_val;

   mem_init_rom u_rom (
      .idx_i (cnt_q[ROM_IDX_W-1:0]),
      .val_o (rom_val)
   );

   // Write data, end-of-target detection and the follow-on target for the current state.
   always_comb begin
      data_d     = '0;
      last_d     = 1'b0;
      next_tgt_d = S_IDLE;
      case (state_q)
         S_BTB: begin
            last_d     = (cnt_q == BTB_LAST);
            next_tgt_d = S_BHT;
         end
         S_BHT: begin
            data_d[1:0] = BHT_INIT;
            last_d      = (cnt_q == BHT_LAST);
            next_tgt_d  = flush_q ? S_IDLE : S_REG;
         end
         S_REG: begin
            data_d     = DATA_W'(cnt_q);
            last_d     = (cnt_q == REG_LAST);
            next_tgt_d = S_MEM;
         end
         S_MEM: begin
            data_d     = DATA_W'(rom_val);
            last_d     = (cnt_q == MEM_LAST);
            next_tgt_d = S_IDLE;
         end
         default: begin
            data_d     = '0;
            last_d     = 1'b0;
            next_tgt_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_BTB;
         cnt_q    <= '0;
         flush_q  <= 1'b0;
         btb_we_q <= 1'b0;
         bht_we_q <= 1'b0;
         reg_we_q <= 1'b0;
         mem_we_q <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         busy_q   <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         btb_we_q <= (state_q == S_BTB);
         bht_we_q <= (state_q == S_BHT);
         reg_we_q <= (state_q == S_REG);
         mem_we_q <= (state_q == S_MEM);
         if (state_q == S_IDLE) begin
            addr_q <= '0;
            data_q <= '0;
            cnt_q  <= '0;
            // busy_q still high on the first idle edge, so a request there is dropped.
            if (!busy_q && start_i) begin
               state_q <= S_BTB;
               flush_q <= 1'b0;
               busy_q  <= 1'b1;
               done_q  <= 1'b0;
            end else if (!busy_q && bp_flush_i) begin
               state_q <= S_BTB;
               flush_q <= 1'b1;
               busy_q  <= 1'b1;
            end else begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end else begin
            addr_q <= cnt_q;
            data_q <= data_d;
            busy_q <= 1'b1;
            if (last_d) begin
               cnt_q   <= '0;
               state_q <= next_tgt_d;
            end else begin
               cnt_q <= cnt_q + 8'd1;
            end
         end
      end
   end

   assign btb_we_o    = btb_we_q;
   assign bht_we_o    = bht_we_q;
   assign reg_we_o    = reg_we_q;
   assign mem_we_o    = mem_we_q;
   assign init_addr_o = addr_q;
   assign init_data_o = data_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_init_sequencer.sv
// Self-checking bench for init_sequencer: every write cycle is compared with a walk model
// derived from target order, depths and the init-data rules.
module tb_init_sequencer;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        bp_flush_i;
   logic        btb_we_o;
   logic        bht_we_o;
   logic        reg_we_o;
   logic        mem_we_o;
   logic [7:0]  init_addr_o;
   logic [39:0] init_data_o;
   logic        busy_o;
   logic        done_o;

   int n_cmp = 0;
   int n_err = 0;

   logic [39:0] mem_seen [27];
   logic [39:0] reg5_seen;
   logic [39:0] bp_data_or;

   always #5 clk = ~clk;

   init_sequencer dut (
      .clk         (clk),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .bp_flush_i  (bp_flush_i),
      .btb_we_o    (btb_we_o),
      .bht_we_o    (bht_we_o),
      .reg_we_o    (reg_we_o),
      .mem_we_o    (mem_we_o),
      .init_addr_o (init_addr_o),
      .init_data_o (init_data_o),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   // Write k of a walk: BTB 0..255, BHT 256..511, REG 512..543, MEM 544..570.
   function automatic void ref_write(input int k, output int tgt, output int addr, output logic [39:0] data);
      if (k < 256) begin
         tgt = 0; addr = k; data = 40'd0;
      end else if (k < 512) begin
         tgt = 1; addr = k - 256; data = 40'd0;
      end else if (k < 544) begin
         tgt = 2; addr = k - 512; data = 40'(addr);
      end else begin
         tgt = 3; addr = k - 544;
         if (addr < 9)       data = 40'(9 - addr);
         else if (addr < 18) data = 40'(addr - 8);
         else                data = 40'd0;
      end
   endfunction

   task automatic check_reset_values(input string name);
      n_cmp++;
      if ({btb_we_o, bht_we_o, reg_we_o, mem_we_o} !== 4'b0 || init_addr_o !== 8'd0 ||
          init_data_o !== 40'd0 || busy_o !== 1'b1 || done_o !== 1'b0) begin
         n_err++;
         $display("FAIL %s: we=%b addr=%0d data=%0h busy=%b done=%b, required we=0000 addr=0 data=0 busy=1 done=0",
                  name, {btb_we_o, bht_we_o, reg_we_o, mem_we_o}, init_addr_o, init_data_o, busy_o, done_o);
      end
   endtask

   // Caller sits between edges; the next rising edge must present write 0.
   task automatic expect_walk(input bit full, input bit exp_done, input int inj_k, input bit inj_start,
                              input bit inj_flush, input int stop_after, input string name);
      int n;
      int bad;
      int first_bad;
      int tgt;
      int addr;
      int cnt [4];
      logic [39:0] d;
      logic [3:0] got_we;
      logic [3:0] exp_we;
      n = full ? 571 : 512;
      bad = 0;
      first_bad = -1;
      cnt = '{0, 0, 0, 0};
      for (int k = 0; k < n; k++) begin
         start_i    = inj_start && (k == inj_k);
         bp_flush_i = inj_flush && (k == inj_k);
         @(posedge clk);
         #1;
         ref_write(k, tgt, addr, d);
         got_we = {mem_we_o, reg_we_o, bht_we_o, btb_we_o};
         exp_we = 4'b0001 << tgt;
         for (int t = 0; t < 4; t++) if (got_we[t] === 1'b1) cnt[t]++;
         if (got_we !== exp_we || init_addr_o !== 8'(addr) || init_data_o !== d ||
             busy_o !== 1'b1 || done_o !== exp_done) begin
            bad++;
            if (first_bad < 0) first_bad = k;
         end
         if (tgt == 2 && addr == 5) reg5_seen = init_data_o;
         if (tgt == 3) mem_seen[addr] = init_data_o;
         if (tgt < 2) bp_data_or = bp_data_or | init_data_o;
         if (k == stop_after) break;
      end
      start_i    = 1'b0;
      bp_flush_i = 1'b0;
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL %s sequence: %0d bad write cycles (first at write %0d), required 0", name, bad, first_bad);
      end
      if (stop_after < 0) begin
         n_cmp++;
         if (cnt[0] != 256 || cnt[1] != 256 || cnt[2] != (full ? 32 : 0) || cnt[3] != (full ? 27 : 0)) begin
            n_err++;
            $display("FAIL %s we_counts: btb=%0d bht=%0d reg=%0d mem=%0d, required 256/256/%0d/%0d",
                     name, cnt[0], cnt[1], cnt[2], cnt[3], full ? 32 : 0, full ? 27 : 0);
         end
         @(posedge clk);
         #1;
         n_cmp++;
         if ({btb_we_o, bht_we_o, reg_we_o, mem_we_o} !== 4'b0 || busy_o !== 1'b0 || done_o !== 1'b1) begin
            n_err++;
            $display("FAIL %s end_edge: we=%b busy=%b done=%b, required we=0000 busy=0 done=1",
                     name, {btb_we_o, bht_we_o, reg_we_o, mem_we_o}, busy_o, done_o);
         end
      end
   endtask

   task automatic idle(input int n, input string name);
      int bad;
      bad = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if ({btb_we_o, bht_we_o, reg_we_o, mem_we_o} !== 4'b0 || busy_o !== 1'b0 || done_o !== 1'b1) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL %s idle: %0d of %0d cycles not idle, required 0", name, bad, n);
      end
   endtask

   task automatic request(input bit s, input bit f, input string name);
      start_i    = s;
      bp_flush_i = f;
      @(posedge clk);
      #1;
      start_i    = 1'b0;
      bp_flush_i = 1'b0;
      n_cmp++;
      if ({btb_we_o, bht_we_o, reg_we_o, mem_we_o} !== 4'b0 || busy_o !== 1'b1 || done_o !== !s) begin
         n_err++;
         $display("FAIL %s accept_edge: we=%b busy=%b done=%b, required we=0000 busy=1 done=%b",
                  name, {btb_we_o, bht_we_o, reg_we_o, mem_we_o}, busy_o, done_o, !s);
      end
   endtask

   task automatic test_reset();
      rst_i      = 1'b1;
      start_i    = 1'b0;
      bp_flush_i = 1'b0;
      #12;
      check_reset_values("reset");
      @(negedge clk);
      rst_i = 1'b0;
   endtask

   task automatic test_full_walk();
      bp_data_or = '0;
      expect_walk(1'b1, 1'b0, -1, 1'b0, 1'b0, -1, "power_on");
   endtask

   task automatic test_data();
      int idx [5] = '{0, 8, 9, 17, 26};
      int val [5] = '{9, 1, 1, 9, 0};
      n_cmp++;
      if (reg5_seen !== 40'd5) begin
         n_err++;
         $display("FAIL reg5_data: got %0d, required 5", reg5_seen);
      end
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (mem_seen[idx[i]] !== 40'(val[i])) begin
            n_err++;
            $display("FAIL mem%0d_data: got %0d, required %0d", idx[i], mem_seen[idx[i]], val[i]);
         end
      end
      n_cmp++;
      if (bp_data_or !== 40'd0) begin
         n_err++;
         $display("FAIL btb_bht_data: OR of data is %0h, required 0", bp_data_or);
      end
   endtask

   task automatic test_flush();
      idle($urandom_range(20, 1), "pre_flush");
      request(1'b0, 1'b1, "flush");
      expect_walk(1'b0, 1'b1, $urandom_range(511, 0), 1'b1, 1'($urandom_range(1, 0)), -1, "flush");
   endtask

   task automatic test_start_and_flush();
      idle($urandom_range(20, 1), "pre_both");
      request(1'b1, 1'b1, "both");
      expect_walk(1'b1, 1'b0, -1, 1'b0, 1'b0, -1, "start_and_flush");
   endtask

   task automatic test_start_in_reg();
      idle($urandom_range(20, 1), "pre_reg");
      request(1'b1, 1'b0, "start");
      expect_walk(1'b1, 1'b0, $urandom_range(543, 512), 1'b1, 1'($urandom_range(1, 0)), -1, "start_in_reg");
   endtask

   task automatic test_reset_mid_mem();
      idle($urandom_range(20, 1), "pre_rst");
      request(1'b1, 1'b0, "start_rst");
      expect_walk(1'b1, 1'b0, -1, 1'b0, 1'b0, 554, "pre_reset");
      #2;
      rst_i = 1'b1;
      #1;
      check_reset_values("async_reset_mem10");
      @(negedge clk);
      rst_i = 1'b0;
      expect_walk(1'b1, 1'b0, -1, 1'b0, 1'b0, -1, "after_reset");
   endtask

   task automatic test_random_requests();
      int kind;
      for (int i = 0; i < 3; i++) begin
         kind = $urandom_range(2, 0);
         idle($urandom_range(30, 1), "rand_idle");
         request(kind != 1, kind != 0, "rand_req");
         expect_walk(kind != 1, kind == 1, $urandom_range(510, 0), 1'($urandom_range(1, 0)),
                     1'($urandom_range(1, 0)), -1, "rand_walk");
      end
   endtask

   initial begin
      test_reset();
      test_full_walk();
      test_data();
      test_flush();
      test_start_and_flush();
      test_start_in_reg();
      test_reset_mid_mem();
      test_random_requests();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
